// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory read port, branch redirect input
// and the valid/ready instruction handoff to the decoder.
//   master : fetch stage (drives imem_addr/imem_rd, instr*, halted)
//   slave  : surrounding system (memory, branch unit, decoder)
interface instruction_fetch_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rd;
  logic [15:0]       imem_data;
  logic              branch_en;
  logic [ADDR_W-1:0] branch_target;
  logic [15:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              halted;

  modport master (
    output imem_addr, imem_rd, instr, instr_pc, instr_valid, halted,
    input  imem_data, branch_en, branch_target, instr_ready
  );

  modport slave (
    input  imem_addr, imem_rd, instr, instr_pc, instr_valid, halted,
    output imem_data, branch_en, branch_target, instr_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage of the 16-bit processor. Holds the PC, reads a synchronous
// instruction memory (one-cycle read latency), buffers fetched words with their
// addresses in a DEPTH-entry prefetch FIFO and presents the FIFO head to the
// decoder. Handles taken-branch redirects and stops fetching after HALT.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : instruction_fetch_if.master (imem read port, branch input,
//            instr/instr_pc/instr_valid/instr_ready handoff, halted)
module instruction_fetch #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instruction_fetch_if.master  bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [4:0] OP_HALT = 5'b11111;

  logic [ADDR_W-1:0]              pc_q, pc_d;
  logic [DEPTH-1:0][15:0]         word_q, word_d;
  logic [DEPTH-1:0][ADDR_W-1:0]   addr_q, addr_d;
  logic [PTR_W-1:0]               rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]               count_q, count_d;
  logic                           inflight_q, inflight_d;
  logic [ADDR_W-1:0]              infl_addr_q, infl_addr_d;
  logic                           stale_q, stale_d;
  logic                           halted_q, halted_d;

  logic valid, pop, push, halt_hit, issue;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign valid = (count_q != '0);
  assign pop   = valid & bus.instr_ready;
  // Branch wins over the returning word: its data belongs to the old stream.
  assign push  = inflight_q & ~stale_q & ~bus.branch_en;
  assign halt_hit = push & (bus.imem_data[15:11] == OP_HALT);
  // Occupancy counts the in-flight word so a full FIFO can never overflow;
  // a pop this cycle frees one slot early, which sustains 1 word/cycle.
  assign issue = rst_n & ~halted_q & ~bus.branch_en &
                 ((int'(count_q) + int'(inflight_q)) < (DEPTH + int'(pop)));

  assign bus.imem_rd     = issue;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = valid;
  assign bus.instr       = valid ? word_q[rd_ptr_q] : '0;
  assign bus.instr_pc    = valid ? addr_q[rd_ptr_q] : '0;
  assign bus.halted      = halted_q;

  always_comb begin
    pc_d        = pc_q;
    word_d      = word_q;
    addr_d      = addr_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    inflight_d  = issue;
    infl_addr_d = issue ? pc_q : infl_addr_q;
    // A fetch issued in the same cycle HALT lands must never be delivered.
    stale_d     = issue & halt_hit;
    halted_d    = halted_q;
    if (bus.branch_en) begin
      pc_d     = bus.branch_target;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      stale_d  = 1'b0;
      halted_d = 1'b0;
    end else begin
      if (issue) pc_d = pc_q + ADDR_W'(1);
      if (push) begin
        word_d[wr_ptr_q] = bus.imem_data;
        addr_d[wr_ptr_q] = infl_addr_q;
        wr_ptr_d         = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      if (halt_hit) halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= '0;
      word_q      <= '0;
      addr_q      <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      inflight_q  <= 1'b0;
      infl_addr_q <= '0;
      stale_q     <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      word_q      <= word_d;
      addr_q      <= addr_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      inflight_q  <= inflight_d;
      infl_addr_q <= infl_addr_d;
      stale_q     <= stale_d;
      halted_q    <= halted_d;
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed reset/stream/back-pressure/branch/
// HALT/wrap/reset steps followed by a randomized phase, all checked against a
// program-order reference (expected next PC, memory contents, halt drain).
module tb_instruction_fetch;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 2;
  localparam int AMASK  = (1 << ADDR_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  instruction_fetch_if #(.ADDR_W(ADDR_W)) bus();

  instruction_fetch #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [256];
  always @(posedge clk) if (bus.imem_rd) bus.imem_data <= mem[bus.imem_addr];

  int compared = 0;
  int mismatched = 0;

  // reference model state
  int exp_pc = 0;
  bit drained = 1'b0;
  int stall = 0;
  bit post_branch = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic observe();
    logic [ADDR_W-1:0] a;
    if (!rst_n) begin
      exp_pc = 0; drained = 1'b0; stall = 0; post_branch = 1'b0;
      return;
    end
    if (post_branch) begin
      chk("halt_clear", bus.halted, 0);
      post_branch = 1'b0;
    end
    chk("rd_while_halted", bus.imem_rd & bus.halted, 0);
    if (bus.branch_en) chk("rd_on_branch", bus.imem_rd, 0);
    if (drained) begin
      chk("drained_valid", bus.instr_valid, 0);
      chk("drained_halted", bus.halted, 1);
    end
    if (bus.instr_valid) stall = 0;
    else if (!drained) stall++;
    chk("stall_bound", stall <= 2, 1);
    if (bus.instr_valid && bus.instr_ready) begin
      a = exp_pc[ADDR_W-1:0];
      chk("instr_pc", bus.instr_pc, a);
      chk("instr", bus.instr, mem[a]);
      if (mem[a][15:11] == 5'h1F) begin
        chk("halt_flag", bus.halted, 1);
        drained = 1'b1;
      end
      exp_pc = (exp_pc + 1) & AMASK;
    end
    if (bus.branch_en) begin
      exp_pc = int'(bus.branch_target);
      drained = 1'b0; stall = 0; post_branch = 1'b1;
    end
  endtask

  task automatic sample(); @(negedge clk); observe(); endtask
  task automatic adv(); @(posedge clk); #1; endtask
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin sample(); adv(); end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_rd"}, bus.imem_rd, 0);
    chk({tag, "_addr"}, bus.imem_addr, 0);
    chk({tag, "_valid"}, bus.instr_valid, 0);
    chk({tag, "_instr"}, bus.instr, 0);
    chk({tag, "_ipc"}, bus.instr_pc, 0);
    chk({tag, "_halted"}, bus.halted, 0);
  endtask

  initial begin
    logic [15:0] hold;
    logic [15:0] w;
    bit last_br;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0100 + 16'(i);
    bus.branch_en = 1'b0;
    bus.branch_target = '0;
    bus.instr_ready = 1'b1;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs("reset");

    // release and stream
    rst_n = 1'b1;
    sample(); chk("first_rd", bus.imem_rd, 1); chk("first_addr", bus.imem_addr, 0);
    chk("c0_valid", bus.instr_valid, 0); adv();
    sample(); chk("c1_valid", bus.instr_valid, 0); chk("c1_addr", bus.imem_addr, 1); adv();
    sample(); chk("c2_valid", bus.instr_valid, 1); chk("c2_instr", bus.instr, 16'h0100);
    chk("c2_pc", bus.instr_pc, 0); adv();
    for (int i = 0; i < 8; i++) begin
      sample(); chk("thru_valid", bus.instr_valid, 1); adv();
    end

    // back-pressure for 5 cycles
    bus.instr_ready = 1'b0;
    hold = bus.instr;
    for (int i = 0; i < 5; i++) begin
      sample();
      chk("bp_rd", bus.imem_rd, 0);
      chk("bp_stable", bus.instr, hold);
      chk("bp_valid", bus.instr_valid, 1);
      adv();
    end

    // branch to 0x40 while FIFO is full
    bus.branch_en = 1'b1; bus.branch_target = 8'h40;
    sample(); chk("br_rd", bus.imem_rd, 0); adv();
    bus.branch_en = 1'b0; bus.instr_ready = 1'b1;
    sample(); chk("br1_valid", bus.instr_valid, 0); chk("br1_rd", bus.imem_rd, 1);
    chk("br1_addr", bus.imem_addr, 8'h40); adv();
    sample(); chk("br2_valid", bus.instr_valid, 0); adv();
    sample(); chk("br3_valid", bus.instr_valid, 1); chk("br3_pc", bus.instr_pc, 8'h40);
    chk("br3_instr", bus.instr, 16'h0140); adv();
    step(4);

    // resume after back-pressure with a pop in the same cycle as release
    bus.instr_ready = 1'b0; step(3);
    bus.instr_ready = 1'b1; step(4);

    // PC wrap
    bus.branch_en = 1'b1; bus.branch_target = 8'hFE;
    sample(); adv();
    bus.branch_en = 1'b0;
    step(2);
    for (int k = 0; k < 4; k++) begin
      sample(); chk("wrap_pc", bus.instr_pc, (8'hFE + k) & AMASK); adv();
    end

    // HALT at word 5
    mem[5] = 16'hF800;
    bus.branch_en = 1'b1; bus.branch_target = 8'h00;
    sample(); adv();
    bus.branch_en = 1'b0;
    step(12);
    sample(); chk("halt_halted", bus.halted, 1); chk("halt_valid", bus.instr_valid, 0);
    chk("halt_rd", bus.imem_rd, 0); adv();
    mem[5] = 16'h0105;
    bus.branch_en = 1'b1; bus.branch_target = 8'h00;
    sample(); adv();
    bus.branch_en = 1'b0;
    sample(); chk("restart_rd", bus.imem_rd, 1); chk("restart_addr", bus.imem_addr, 0); adv();
    step(8);

    // reset mid-stream
    chk("pre_reset_valid", bus.instr_valid, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("midrst");
    sample(); adv();
    rst_n = 1'b1;
    sample(); chk("rst_restart_rd", bus.imem_rd, 1); chk("rst_restart_addr", bus.imem_addr, 0); adv();
    step(6);

    // randomized phase with fresh memory image loaded under reset
    rst_n = 1'b0;
    for (int i = 0; i < 256; i++) begin
      w = 16'($urandom);
      if (w[15:11] == 5'h1F) w[15] = 1'b0;
      if ($urandom_range(0, 24) == 0) w[15:11] = 5'h1F;
      mem[i] = w;
    end
    sample(); adv();
    rst_n = 1'b1;
    last_br = 1'b0;
    for (int i = 0; i < 800; i++) begin
      bus.instr_ready = ($urandom_range(0, 3) != 0);
      if (!last_br && (drained ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0))) begin
        bus.branch_en = 1'b1;
        bus.branch_target = ADDR_W'($urandom);
      end else begin
        bus.branch_en = 1'b0;
      end
      last_br = bus.branch_en;
      sample(); adv();
    end
    bus.branch_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the simple 16-bit processor, directly upstream of the instruction decoder. It holds the program counter and reads the synchronous instruction memory. Fetched 16-bit words are buffered in a small prefetch FIFO and handed to the decoder over a valid/ready handshake. It also handles taken-branch redirects (flush plus PC reload) and stops fetching after a HALT opcode.

## Interface
Parameters:
- ADDR_W, 8, program-counter / instruction-memory address width (word addressed)
- DEPTH, 2, prefetch FIFO entries (≥2)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- imem_addr  output  ADDR_W  read address to instruction memory (= pc)
- imem_rd  output  1  read strobe; data for the addressed word returns on imem_data the next cycle
- imem_data  input  16  instruction word, valid the cycle after imem_rd
- branch_en  input  1  taken-branch redirect request (single-cycle pulse)
- branch_target  input  ADDR_W  new PC, sampled when branch_en=1
- instr  output  16  instruction to decoder (FIFO head; opcode = instr[15:11])
- instr_pc  output  ADDR_W  address instr was fetched from
- instr_valid  output  1  instr/instr_pc valid
- instr_ready  input  1  decoder accepts; transfer when instr_valid & instr_ready
- halted  output  1  fetch stopped by HALT opcode

## Operation
- State: pc, FIFO of {word, addr} × DEPTH, count, inflight flag + inflight addr, stale flag, halted.
- pop = instr_valid & instr_ready.
- issue = rst_n & ~halted & ~branch_en & (count + inflight − pop < DEPTH).
- On issue: imem_rd=1, imem_addr=pc. Set inflight with addr=pc, and pc ← pc+1 mod 2^ADDR_W, so 255 wraps to 0 for ADDR_W=8.
- Return: in the cycle after an issue, if inflight & ~stale, push {imem_data, inflight addr} into the FIFO. If stale, drop the data.
- Push and pop in the same cycle are both performed. Count never exceeds DEPTH, which the issue rule guarantees.
- HALT: when the pushed word has [15:11]=5'b11111, set halted=1.
  - No further issue.
  - A fetch already in flight at that point is discarded (marked stale); the HALT word is the last pushed.
  - Buffered words still drain to the decoder.
- Branch (branch_en=1 at an edge):
  - pc ← branch_target.
  - FIFO cleared (count=0).
  - Any outstanding return marked stale.
  - halted ← 0.
  - imem_rd=0 that cycle.
  - A pop in the same cycle still counts as a completed transfer.
  - Branch has priority over push, HALT and issue.
- instr/instr_pc/instr_valid come from the FIFO head; instr_valid = (count≠0). Head contents are stable while instr_valid & ~instr_ready and no branch occurs.

## Timing
- Reset (async, immediate): pc=0, count=0, inflight=0, stale=0, halted=0. Outputs: imem_rd=0, imem_addr=0, instr_valid=0, instr=16'h0000, instr_pc=0, halted=0.
- First cycle after rst_n rises: imem_rd=1, imem_addr=0.
- Fetch latency: issue in cycle t → data on imem_data in t+1, captured at the end of t+1 → instr_valid=1 in t+2 (2 cycles).
- Throughput: 1 instruction/cycle with instr_ready held high (steady state count=1, inflight=1).
- Back-pressure: with instr_ready=0, issuing stops once count+inflight=DEPTH. No word is lost or duplicated.
- Branch in cycle b:
  - instr_valid=0 in b+1.
  - imem_rd=1 with imem_addr=branch_target in b+1.
  - First target instruction valid in b+3.
- Reset mid-operation clears everything immediately. Stale returns after reset are ignored because inflight=0.

## Test plan
- Reset/stream: memory word[i]=16'h0100+i, instr_ready=1, release reset. Expect imem_rd=1 with addr 0 in the first cycle, instr_valid from cycle 2, and instr sequence 0100, 0101, 0102… on consecutive cycles with instr_pc 0, 1, 2….
- Back-pressure: hold instr_ready=0 for 5 cycles mid-stream. Expect imem_rd low after 2 outstanding and instr held stable. On release, the sequence resumes with no gap or duplicate.
- Branch: pulse branch_en with target 8'h40 while the FIFO holds 2 entries. Expect instr_valid=0 the next cycle, the stale in-flight word dropped, and instr_pc=8'h40 with instr=word[0x40] three cycles after the pulse.
- HALT: word[5]=16'hF800. Expect instructions 0–5 delivered, halted=1, no imem_rd after the HALT push, and instr_valid=0 after word 5 pops. Then branch_en with target 0: halted=0 and fetch restarts at 0.
- Wrap: branch to 8'hFE with stream running. Expect instr_pc FE, FF, 00, 01.
- Reset mid-stream: drop rst_n while instr_valid=1. Expect all outputs at reset values immediately, and fetch restarting at addr 0 after release.
